// File: rtl/keyed_lut_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keyed_lut_lock: per-channel key-defined LUT + XOR flip, serial key load     |
// | with atomic commit and armed output gate.           Rev 1.0                 |
// +----------------------------------------------------------------------------+
module keyed_lut_lock #(
  parameter int NUM_CH       = 4,
  parameter int LUT_IN       = 2,
  parameter int ALLOW_RELOAD = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_start_i,
  input  logic                     key_bit_i,
  input  logic                     key_bit_valid_i,
  output logic                     key_bit_ready_o,
  output logic                     armed_o,
  output logic                     key_err_o,
  input  logic [NUM_CH*LUT_IN-1:0] sel_i,
  input  logic                     in_valid_i,
  output logic [NUM_CH-1:0]        out_data_o,
  output logic                     out_valid_o
);

  localparam int LUT_N = 1 << LUT_IN;
  localparam int SEG_W = LUT_N + 1;
  localparam int KEY_W = NUM_CH * SEG_W;
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   active_q, active_d;
  logic               key_err_q, key_err_d;
  logic [NUM_CH-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [NUM_CH-1:0]  w_lut_res;
  logic               w_armed;
  logic               w_armed_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      key_err_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      key_err_q   <= key_err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    key_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // A restart discards any bit presented alongside it.
        if (key_start_i) begin
          cnt_d     = '0;
          key_err_d = 1'b1;
        end else if (key_bit_valid_i) begin
          for (int i = 0; i < KEY_W; i++) begin
            if (cnt_q == CNT_W'(i)) shadow_d[i] = key_bit_i;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_W - 1)) begin
            active_d = shadow_d;
            state_d  = ARMED;
          end
        end
      end
      ARMED: begin
        if (key_start_i) begin
          if (ALLOW_RELOAD != 0) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LUT_N-1:0]  w_lut;
    logic              w_xk;
    logic [LUT_IN-1:0] w_sel;
    assign w_lut        = active_q[c*SEG_W +: LUT_N];
    assign w_xk         = active_q[c*SEG_W + LUT_N];
    assign w_sel        = sel_i[c*LUT_IN +: LUT_IN];
    assign w_lut_res[c] = w_lut[w_sel] ^ w_xk;
  end

  assign w_armed      = (state_q == ARMED);
  assign w_armed_next = (state_d == ARMED);

  always_comb begin
    out_valid_d = in_valid_i & w_armed;
    out_data_d  = out_data_q;
    if (in_valid_i && w_armed) begin
      out_data_d = w_lut_res;
    end else if (w_armed && !w_armed_next) begin
      out_data_d = '0;
    end
  end

  assign key_bit_ready_o = (state_q == SHIFT);
  assign armed_o         = w_armed;
  assign key_err_o       = key_err_q;
  assign out_data_o      = out_data_q;
  assign out_valid_o     = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keyed_lut_lock.sv
`default_nettype none
// Bench: two instances (reload allowed / sealed) driven by shared stimulus and
// compared every cycle against a key-rule model, plus directed sequences.
module tb_keyed_lut_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0;
  logic       key_bit = 1'b0;
  logic       kbv = 1'b0;
  logic [3:0] sel = 4'h0;
  logic       in_valid = 1'b0;

  logic [1:0] rdy, armo, erro, ovo;
  logic [1:0] od [2];

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  keyed_lut_lock #(.NUM_CH(2), .LUT_IN(2), .ALLOW_RELOAD(1)) dut_r (
    .clk(clk), .rst(rst), .key_start_i(key_start), .key_bit_i(key_bit),
    .key_bit_valid_i(kbv), .key_bit_ready_o(rdy[0]), .armed_o(armo[0]),
    .key_err_o(erro[0]), .sel_i(sel), .in_valid_i(in_valid),
    .out_data_o(od[0]), .out_valid_o(ovo[0]));

  keyed_lut_lock #(.NUM_CH(2), .LUT_IN(2), .ALLOW_RELOAD(0)) dut_s (
    .clk(clk), .rst(rst), .key_start_i(key_start), .key_bit_i(key_bit),
    .key_bit_valid_i(kbv), .key_bit_ready_o(rdy[1]), .armed_o(armo[1]),
    .key_err_o(erro[1]), .sel_i(sel), .in_valid_i(in_valid),
    .out_data_o(od[1]), .out_valid_o(ovo[1]));

  // Reference model: index 0 = reload allowed, 1 = sealed.
  bit         m_ld [2];
  bit         m_arm [2];
  int         m_cnt [2];
  logic [9:0] m_shadow [2];
  logic [9:0] m_active [2];
  logic       m_err [2];
  logic       m_ov [2];
  logic [1:0] m_od [2];

  typedef struct {
    logic [3:0] sel;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl [5];

  function automatic logic [1:0] lut_eval(input logic [9:0] key, input logic [3:0] s);
    logic [1:0] r;
    for (int c = 0; c < 2; c++) begin
      int idx;
      idx  = (int'(s) >> (2 * c)) & 3;
      r[c] = key[c*5 + idx] ^ key[c*5 + 4];
    end
    return r;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_ld[m] = 0; m_arm[m] = 0; m_cnt[m] = 0;
        m_shadow[m] = '0; m_active[m] = '0;
        m_err[m] = 0; m_ov[m] = 0; m_od[m] = '0;
      end else begin
        bit was;
        logic [1:0] res;
        was      = m_arm[m];
        res      = lut_eval(m_active[m], sel);
        m_err[m] = 0;
        m_ov[m]  = in_valid && was;
        if (m_ld[m]) begin
          if (key_start) begin
            m_cnt[m] = 0;
            m_err[m] = 1;
          end else if (kbv) begin
            m_shadow[m][m_cnt[m]] = key_bit;
            m_cnt[m]++;
            if (m_cnt[m] == 10) begin
              m_active[m] = m_shadow[m];
              m_ld[m] = 0;
              m_arm[m] = 1;
            end
          end
        end else if (m_arm[m]) begin
          if (key_start) begin
            if (m == 0) begin
              m_ld[m] = 1; m_arm[m] = 0; m_cnt[m] = 0;
            end else begin
              m_err[m] = 1;
            end
          end
        end else if (key_start) begin
          m_ld[m] = 1; m_cnt[m] = 0;
        end
        if (in_valid && was) m_od[m] = res;
        else if (was && !m_arm[m]) m_od[m] = '0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("cyc%0d_ready", m), 10'(rdy[m]),  10'(m_ld[m]));
      chk($sformatf("cyc%0d_armed", m), 10'(armo[m]), 10'(m_arm[m]));
      chk($sformatf("cyc%0d_err", m),   10'(erro[m]), 10'(m_err[m]));
      chk($sformatf("cyc%0d_ovalid", m), 10'(ovo[m]), 10'(m_ov[m]));
      chk($sformatf("cyc%0d_odata", m), 10'(od[m]),   10'(m_od[m]));
    end
  endtask

  task automatic load(input logic [9:0] k, input bit gap);
    key_start = 1; tick(); key_start = 0;
    for (int i = 0; i < 10; i++) begin
      if (gap) begin
        kbv = 0; key_bit = ~k[i]; tick();
      end
      kbv = 1; key_bit = k[i]; tick();
      if (i == 8) chk("pre_commit_armed", 10'(armo[0]), 10'd0);
    end
    kbv = 0;
    chk("commit_armed", 10'(armo[0]), 10'd1);
    chk("commit_ready", 10'(rdy[0]), 10'd0);
  endtask

  initial begin
    tbl[0] = '{4'b1111, 2'b11};
    tbl[1] = '{4'b0101, 2'b00};
    tbl[2] = '{4'b0011, 2'b11};
    tbl[3] = '{4'b0000, 2'b10};
    tbl[4] = '{4'b1100, 2'b10};

    rst = 1; tick(); tick(); rst = 0;
    chk("rst_armed", 10'(armo[0]), 10'd0);
    chk("rst_odata", 10'(od[0]), 10'd0);

    // Load 10'h2C8 and exercise the LUT table.
    load(10'h2C8, 0);
    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].sel; in_valid = 1; tick();
      chk($sformatf("tbl%0d_odata", i), 10'(od[0]), 10'(tbl[i].exp));
      chk($sformatf("tbl%0d_ovalid", i), 10'(ovo[0]), 10'd1);
    end
    in_valid = 0;

    // Reload attempt: sealed instance refuses, reload instance disarms.
    key_start = 1; tick(); key_start = 0;
    chk("seal_err", 10'(erro[1]), 10'd1);
    chk("seal_armed", 10'(armo[1]), 10'd1);
    chk("seal_odata", 10'(od[1]), 10'b10);
    chk("reload_armed", 10'(armo[0]), 10'd0);
    chk("reload_odata", 10'(od[0]), 10'd0);
    chk("reload_ready", 10'(rdy[0]), 10'd1);

    // Abort after 5 bits, then a fresh all-zero key.
    for (int i = 0; i < 5; i++) begin
      kbv = 1; key_bit = 1'($urandom_range(0, 1)); tick();
    end
    key_start = 1; key_bit = 1; tick(); key_start = 0;
    chk("abort_err", 10'(erro[0]), 10'd1);
    kbv = 0; tick();
    chk("abort_err_clear", 10'(erro[0]), 10'd0);
    for (int i = 0; i < 10; i++) begin
      kbv = 1; key_bit = 0; tick();
    end
    kbv = 0;
    chk("zero_commit_armed", 10'(armo[0]), 10'd1);
    sel = 4'($urandom_range(0, 15)); in_valid = 1; tick(); in_valid = 0;
    chk("zero_key_odata", 10'(od[0]), 10'd0);

    // Gapped key delivery.
    load(10'h2C8, 1);
    sel = 4'b1111; in_valid = 1; tick(); in_valid = 0;
    chk("gap_key_odata", 10'(od[0]), 10'b11);

    // Reset in the middle of a load.
    key_start = 1; tick(); key_start = 0;
    for (int i = 0; i < 4; i++) begin
      kbv = 1; key_bit = 1; tick();
    end
    kbv = 0; rst = 1; tick(); rst = 0;
    chk("midrst_ready", 10'(rdy[0]), 10'd0);
    chk("midrst_armed", 10'(armo[0]), 10'd0);
    in_valid = 1; tick(); in_valid = 0;
    chk("midrst_ovalid", 10'(ovo[0]), 10'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 399) == 0);
      key_start = ($urandom_range(0, 29) == 0);
      kbv       = 1'($urandom_range(0, 1));
      key_bit   = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 0; key_start = 0; kbv = 0; in_valid = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
